// File: rtl/spi_arb_if.sv
// Handshake bundle between the two SPI requesters, the shared 16-bit SPI master and spi_arb.
// slave = arbiter view, master = environment (requesters + SPI master) view.
interface spi_arb_if;
   logic        req0, req1;
   logic        lock0, lock1;
   logic [15:0] cmd0, cmd1;
   logic        done0, done1;
   logic [15:0] rd_data0, rd_data1;
   logic        wrt;
   logic [15:0] cmd;
   logic        done;
   logic [15:0] rd_data;
   logic        SS_n;
   logic        SS0_n, SS1_n;
   logic        err;

   modport slave (
      input  req0, req1, lock0, lock1, cmd0, cmd1, done, rd_data, SS_n,
      output done0, done1, rd_data0, rd_data1, wrt, cmd, SS0_n, SS1_n, err
   );

   modport master (
      output req0, req1, lock0, lock1, cmd0, cmd1, done, rd_data, SS_n,
      input  done0, done1, rd_data0, rd_data1, wrt, cmd, SS0_n, SS1_n, err
   );
endinterface

// File: rtl/spi_arb.sv
// Two-port round-robin arbiter sharing one SPI master, with locked bursts.
// Optional BUSY timeout abort enabled by defining SPI_ARB_TMO_EN.
module spi_arb #(
   parameter int TMO_CYC = 4096
) (
   input logic     clk,
   input logic     rst_n,
   spi_arb_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, GAP} state_t;

   state_t           state, state_nxt;
   logic             owner, owner_nxt;
   logic             prio, prio_nxt;
   logic             load_cmd;
   logic [1:0]       req, lock, done_q;
   logic [1:0][15:0] cmd_in, rdat_q;
   logic [15:0]      cmd_q;
   logic             tmo, tmo_seen;

   assign req    = {bus.req1, bus.req0};
   assign lock   = {bus.lock1, bus.lock0};
   assign cmd_in = {bus.cmd1, bus.cmd0};

`ifdef SPI_ARB_TMO_EN
   logic [15:0] tmo_cnt;

   // tmo_seen makes the following GAP ignore lock so an aborted owner loses the bus
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt  <= '0;
         tmo_seen <= 1'b0;
      end else begin
         if (state == LAUNCH)    tmo_cnt <= '0;
         else if (state == BUSY) tmo_cnt <= tmo_cnt + 16'd1;
         if (tmo)                tmo_seen <= 1'b1;
         else if (state == GAP)  tmo_seen <= 1'b0;
      end
   end

   assign tmo = (state == BUSY) && !bus.done && (tmo_cnt == 16'(TMO_CYC - 1));
`else
   // never fires; keeps the parameter referenced in the default build
   assign tmo      = (TMO_CYC < 0);
   assign tmo_seen = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      prio_nxt  = prio;
      load_cmd  = 1'b0;
      case (state)
         IDLE: begin
            if (|req) begin
               owner_nxt = (&req) ? prio : req[1];
               load_cmd  = 1'b1;
               state_nxt = LAUNCH;
            end
         end
         LAUNCH: state_nxt = BUSY;
         BUSY: begin
            if (bus.done || tmo) state_nxt = GAP;
         end
         GAP: begin
            if (!tmo_seen && lock[owner] && req[owner]) begin
               load_cmd  = 1'b1;
               state_nxt = LAUNCH;
            end else begin
               prio_nxt  = ~owner;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         owner  <= 1'b0;
         prio   <= 1'b0;
         cmd_q  <= '0;
         done_q <= '0;
         rdat_q <= '0;
      end else begin
         state  <= state_nxt;
         owner  <= owner_nxt;
         prio   <= prio_nxt;
         done_q <= '0;
         if (load_cmd) cmd_q <= cmd_in[owner_nxt];
         // master done is only honoured while a transaction is outstanding
         if (state == BUSY && bus.done) begin
            done_q[owner] <= 1'b1;
            rdat_q[owner] <= bus.rd_data;
         end
      end
   end

   assign bus.wrt      = (state == LAUNCH);
   assign bus.cmd      = cmd_q;
   assign bus.done0    = done_q[0];
   assign bus.done1    = done_q[1];
   assign bus.rd_data0 = rdat_q[0];
   assign bus.rd_data1 = rdat_q[1];
   assign bus.err      = tmo;
   assign bus.SS0_n    = (state != IDLE && !owner) ? bus.SS_n : 1'b1;
   assign bus.SS1_n    = (state != IDLE &&  owner) ? bus.SS_n : 1'b1;
endmodule
